// File: rtl/wb_stage_gen2.sv
// Write-back stage: one-deep WB slot, architectural HI/LO, retirement and
// bubble counters, and a first-word-fall-through debug trace FIFO.
module wb_stage_gen2 #(
    parameter int DATA_W      = 32,
    parameter int RADDR_W     = 5,
    parameter int TRACE_DEPTH = 4,
    parameter int HILO_EN     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [5:0]         stall,
    input  logic               in_valid,
    input  logic [31:0]        in_pc,
    input  logic               in_rf_we,
    input  logic [RADDR_W-1:0] in_rf_waddr,
    input  logic [DATA_W-1:0]  in_rf_wdata,
    input  logic               in_hi_we,
    input  logic               in_lo_we,
    input  logic [DATA_W-1:0]  in_hi,
    input  logic [DATA_W-1:0]  in_lo,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic [DATA_W-1:0]  hi_q,
    output logic [DATA_W-1:0]  lo_q,
    output logic [DATA_W-1:0]  hi_fwd,
    output logic [DATA_W-1:0]  lo_fwd,
    output logic [31:0]        debug_wb_pc,
    output logic [3:0]         debug_wb_rf_wen,
    output logic [RADDR_W-1:0] debug_wb_rf_wnum,
    output logic [DATA_W-1:0]  debug_wb_rf_wdata,
    output logic               trace_valid,
    input  logic               trace_ready,
    output logic [31:0]        trace_pc,
    output logic [RADDR_W-1:0] trace_waddr,
    output logic [DATA_W-1:0]  trace_wdata,
    output logic               trace_ovf,
    output logic [31:0]        retire_cnt,
    output logic [31:0]        bubble_cnt
);

    localparam int PTR_W = $clog2(TRACE_DEPTH);

    logic               slot_valid;
    logic [31:0]        slot_pc;
    logic               slot_rf_we;
    logic [RADDR_W-1:0] slot_waddr;
    logic [DATA_W-1:0]  slot_wdata;
    logic               slot_hi_we;
    logic               slot_lo_we;
    logic [DATA_W-1:0]  slot_hi;
    logic [DATA_W-1:0]  slot_lo;

    logic hold, bubble, retire, push, pop, full, empty, do_push;
    logic [PTR_W:0] wptr, rptr;

    logic [31:0]        mem_pc    [TRACE_DEPTH];
    logic [RADDR_W-1:0] mem_waddr [TRACE_DEPTH];
    logic [DATA_W-1:0]  mem_wdata [TRACE_DEPTH];

    // Only the WB and downstream stall bits matter here.
    logic unused_stall;
    assign unused_stall = ^stall[3:0];

    // A flush always empties the slot, so it never counts as holding.
    assign bubble = !flush && stall[4] && !stall[5];
    assign hold   = !flush && stall[4] && stall[5];
    assign retire = slot_valid && !hold;

    assign rf_we             = slot_valid & slot_rf_we;
    assign rf_waddr          = slot_waddr;
    assign rf_wdata          = slot_wdata;
    assign debug_wb_pc       = slot_pc;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = slot_waddr;
    assign debug_wb_rf_wdata = slot_wdata;

    assign hi_fwd = (slot_valid & slot_hi_we) ? slot_hi : hi_q;
    assign lo_fwd = (slot_valid & slot_lo_we) ? slot_lo : lo_q;

    // WB slot: clear on reset/flush/bubble, load when WB is free, else hold.
    always_ff @(posedge clk) begin
        if (rst || flush || bubble) begin
            slot_valid <= 1'b0;
            slot_pc    <= '0;
            slot_rf_we <= 1'b0;
            slot_waddr <= '0;
            slot_wdata <= '0;
            slot_hi_we <= 1'b0;
            slot_lo_we <= 1'b0;
            slot_hi    <= '0;
            slot_lo    <= '0;
        end else if (!stall[4]) begin
            slot_valid <= in_valid;
            slot_pc    <= in_pc;
            slot_rf_we <= in_rf_we;
            slot_waddr <= in_rf_waddr;
            slot_wdata <= in_rf_wdata;
            slot_hi_we <= in_hi_we;
            slot_lo_we <= in_lo_we;
            slot_hi    <= in_hi;
            slot_lo    <= in_lo;
        end
    end

    generate
        if (HILO_EN != 0) begin : g_hilo
            // HI/LO commit once, on the edge where the slot leaves WB.
            always_ff @(posedge clk) begin
                if (rst) begin
                    hi_q <= '0;
                    lo_q <= '0;
                end else if (retire) begin
                    if (slot_hi_we) hi_q <= slot_hi;
                    if (slot_lo_we) lo_q <= slot_lo;
                end
            end
        end else begin : g_no_hilo
            assign hi_q = '0;
            assign lo_q = '0;
        end
    endgenerate

    // Retirement and bubble counters, free-running with natural wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt <= '0;
            bubble_cnt <= '0;
        end else begin
            if (retire) retire_cnt <= retire_cnt + 32'd1;
            if (bubble) bubble_cnt <= bubble_cnt + 32'd1;
        end
    end

    assign empty   = (wptr == rptr);
    assign full    = (wptr[PTR_W] != rptr[PTR_W]) &&
                     (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
    assign push    = retire && rf_we && (slot_waddr != '0);
    assign pop     = trace_valid && trace_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);

    assign trace_valid = !empty;
    assign trace_pc    = trace_valid ? mem_pc[rptr[PTR_W-1:0]]    : '0;
    assign trace_waddr = trace_valid ? mem_waddr[rptr[PTR_W-1:0]] : '0;
    assign trace_wdata = trace_valid ? mem_wdata[rptr[PTR_W-1:0]] : '0;

    // Trace storage; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_pc[wptr[PTR_W-1:0]]    <= slot_pc;
            mem_waddr[wptr[PTR_W-1:0]] <= slot_waddr;
            mem_wdata[wptr[PTR_W-1:0]] <= slot_wdata;
        end
    end

    // Trace pointers and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            trace_ovf <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            if (push && full && !pop) trace_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_stage_gen2.sv
// Directed bench for wb_stage_gen2: load/retire, bubble, hold, HI/LO bypass,
// trace FIFO fill/overflow/simultaneous push-pop/drain, flush and reset.
module tb_wb_stage_gen2;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [5:0]  stall;
   logic        in_valid;
   logic [31:0] in_pc;
   logic        in_rf_we;
   logic [4:0]  in_rf_waddr;
   logic [31:0] in_rf_wdata;
   logic        in_hi_we;
   logic        in_lo_we;
   logic [31:0] in_hi;
   logic [31:0] in_lo;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] hi_q, lo_q, hi_fwd, lo_fwd;
   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;
   logic        trace_valid;
   logic        trace_ready;
   logic [31:0] trace_pc;
   logic [4:0]  trace_waddr;
   logic [31:0] trace_wdata;
   logic        trace_ovf;
   logic [31:0] retire_cnt;
   logic [31:0] bubble_cnt;

   int errors = 0;
   int checks = 0;

   wb_stage_gen2 #(.DATA_W(32), .RADDR_W(5), .TRACE_DEPTH(4), .HILO_EN(1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall),
      .in_valid(in_valid), .in_pc(in_pc), .in_rf_we(in_rf_we),
      .in_rf_waddr(in_rf_waddr), .in_rf_wdata(in_rf_wdata),
      .in_hi_we(in_hi_we), .in_lo_we(in_lo_we), .in_hi(in_hi), .in_lo(in_lo),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .hi_q(hi_q), .lo_q(lo_q), .hi_fwd(hi_fwd), .lo_fwd(lo_fwd),
      .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
      .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
      .trace_valid(trace_valid), .trace_ready(trace_ready),
      .trace_pc(trace_pc), .trace_waddr(trace_waddr), .trace_wdata(trace_wdata),
      .trace_ovf(trace_ovf), .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] wd);
      in_valid    = 1'b1;
      in_pc       = pc;
      in_rf_we    = 1'b1;
      in_rf_waddr = wa;
      in_rf_wdata = wd;
      in_hi_we    = 1'b0;
      in_lo_we    = 1'b0;
      in_hi       = 32'h0;
      in_lo       = 32'h0;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_rf_we = 1'b0;
      in_hi_we = 1'b0;
      in_lo_we = 1'b0;
   endtask

   initial begin
      logic [31:0] drain_pc [4];
      drain_pc[0] = 32'h0000_0100;
      drain_pc[1] = 32'h0000_0200;
      drain_pc[2] = 32'h0000_0400;
      drain_pc[3] = 32'h0000_0600;

      rst = 1'b1; flush = 1'b0; stall = 6'b0; trace_ready = 1'b0;
      in_pc = 32'h0; in_rf_waddr = 5'd0; in_rf_wdata = 32'h0;
      idle();
      in_hi = 32'h0; in_lo = 32'h0;

      // Reset state
      tick(); tick();
      chk("rst_rf_we", rf_we, 1'b0);
      chk("rst_pc", debug_wb_pc, 32'h0);
      chk("rst_hi_q", hi_q, 32'h0);
      chk("rst_retire", retire_cnt, 32'h0);
      chk("rst_bubble", bubble_cnt, 32'h0);
      chk("rst_tvalid", trace_valid, 1'b0);
      chk("rst_ovf", trace_ovf, 1'b0);
      rst = 1'b0;

      // Load and retire
      load(32'hBFC0_0000, 5'd8, 32'h1234);
      tick();
      chk("load_rf_we", rf_we, 1'b1);
      chk("load_wen", debug_wb_rf_wen, 4'hF);
      chk("load_waddr", rf_waddr, 5'd8);
      chk("load_wdata", rf_wdata, 32'h1234);
      chk("load_retire_pre", retire_cnt, 32'd0);
      idle();
      tick();
      chk("ret_cnt1", retire_cnt, 32'd1);
      chk("ret_rf_we_off", rf_we, 1'b0);
      chk("ret_tvalid", trace_valid, 1'b1);
      chk("ret_tpc", trace_pc, 32'hBFC0_0000);
      chk("ret_twaddr", trace_waddr, 5'd8);
      chk("ret_twdata", trace_wdata, 32'h1234);

      // Bubble insertion
      load(32'h0000_0999, 5'd1, 32'h1);
      stall = 6'b010000;
      tick();
      chk("bub_cnt", bubble_cnt, 32'd1);
      chk("bub_rf_we", rf_we, 1'b0);
      chk("bub_pc", debug_wb_pc, 32'h0);
      stall = 6'b0;

      // HI bypass then commit
      load(32'h0000_0100, 5'd3, 32'h33);
      in_hi_we = 1'b1; in_hi = 32'hDEAD;
      tick();
      chk("hi_fwd_now", hi_fwd, 32'hDEAD);
      chk("hi_q_old", hi_q, 32'h0);
      idle();
      tick();
      chk("hi_q_new", hi_q, 32'hDEAD);
      chk("hi_fwd_after", hi_fwd, 32'hDEAD);
      chk("hi_retire", retire_cnt, 32'd2);

      // Hold for three cycles with LO write pending
      load(32'h0000_0200, 5'd5, 32'h55);
      in_lo_we = 1'b1; in_lo = 32'hBEEF;
      tick();
      chk("lo_fwd_now", lo_fwd, 32'hBEEF);
      load(32'h0000_0999, 5'd7, 32'h99);
      stall = 6'b110000;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_pc", debug_wb_pc, 32'h0000_0200);
         chk("hold_retire", retire_cnt, 32'd2);
         chk("hold_lo_q", lo_q, 32'h0);
      end
      chk("hold_bubble", bubble_cnt, 32'd1);
      stall = 6'b0;
      idle();
      tick();
      chk("unhold_retire", retire_cnt, 32'd3);
      chk("unhold_lo_q", lo_q, 32'hBEEF);
      chk("unhold_hi_q", hi_q, 32'hDEAD);

      // waddr=0 retirement: counted, not traced
      load(32'h0000_0300, 5'd0, 32'h77);
      tick();
      idle();
      tick();
      chk("w0_retire", retire_cnt, 32'd4);

      // Fill to four entries
      load(32'h0000_0400, 5'd9, 32'h99);
      tick();
      idle();
      tick();
      chk("full_retire", retire_cnt, 32'd5);
      chk("full_ovf", trace_ovf, 1'b0);
      chk("full_head", trace_pc, 32'hBFC0_0000);

      // Full FIFO with simultaneous push and pop
      load(32'h0000_0600, 5'd11, 32'hAA);
      tick();
      idle();
      trace_ready = 1'b1;
      tick();
      trace_ready = 1'b0;
      chk("sim_ovf", trace_ovf, 1'b0);
      chk("sim_head", trace_pc, 32'h0000_0100);
      chk("sim_retire", retire_cnt, 32'd6);

      // Push into full FIFO without pop: dropped, sticky overflow
      load(32'h0000_0500, 5'd10, 32'hBB);
      tick();
      idle();
      tick();
      chk("ovf_set", trace_ovf, 1'b1);
      chk("ovf_retire", retire_cnt, 32'd7);
      chk("ovf_head", trace_pc, 32'h0000_0100);

      // Drain in order
      trace_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_valid", trace_valid, 1'b1);
         chk("drain_pc", trace_pc, drain_pc[i]);
         tick();
      end
      chk("drain_empty", trace_valid, 1'b0);
      chk("drain_pc0", trace_pc, 32'h0);
      tick();
      chk("empty_pop", trace_valid, 1'b0);
      chk("ovf_sticky", trace_ovf, 1'b1);
      trace_ready = 1'b0;

      // Flush kills incoming instruction
      load(32'h0000_0700, 5'd12, 32'hCC);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      idle();
      chk("flush_rf_we", rf_we, 1'b0);
      chk("flush_pc", debug_wb_pc, 32'h0);
      tick();
      chk("flush_retire", retire_cnt, 32'd7);
      chk("flush_tvalid", trace_valid, 1'b0);

      // Reset with a pending pop
      load(32'h0000_0800, 5'd13, 32'hDD);
      tick();
      idle();
      tick();
      chk("pre_rst_tvalid", trace_valid, 1'b1);
      chk("pre_rst_retire", retire_cnt, 32'd8);
      load(32'h0000_0900, 5'd14, 32'hEE);
      trace_ready = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      trace_ready = 1'b0;
      idle();
      chk("r2_tvalid", trace_valid, 1'b0);
      chk("r2_tpc", trace_pc, 32'h0);
      chk("r2_retire", retire_cnt, 32'h0);
      chk("r2_bubble", bubble_cnt, 32'h0);
      chk("r2_hi_q", hi_q, 32'h0);
      chk("r2_lo_q", lo_q, 32'h0);
      chk("r2_ovf", trace_ovf, 1'b0);
      chk("r2_rf_we", rf_we, 1'b0);
      chk("r2_pc", debug_wb_pc, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_stage_gen2.md
WB_STAGE_GEN2 -- requirements
Module: wb_stage_gen2

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register-file, HI and LO data width.
REQ-002 SHALL have parameter RADDR_W, default 5: register address width.
REQ-003 SHALL have parameter TRACE_DEPTH, default 4 (power of two, >=2): debug trace FIFO depth.
REQ-004 SHALL have parameter HILO_EN, default 1: 0 removes HI/LO state; hi_q and lo_q then read 0.
REQ-005 SHALL clock on `clk` and reset with `rst`; one clock, reset synchronous and active-high.
REQ-006 Ports, listed as name, direction, width, meaning:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- flush, in, 1, kill the incoming MEM instruction.
- stall, in, 6, stall bus; bit 4 = WB stage, bit 5 = downstream; 1 = Stop.
- in_valid, in, 1, MEM slot holds an instruction.
- in_pc, in, 32, instruction PC.
- in_rf_we, in, 1, GPR write enable.
- in_rf_waddr, in, RADDR_W, GPR write address.
- in_rf_wdata, in, DATA_W, GPR write data.
- in_hi_we, in, 1, HI write enable.
- in_lo_we, in, 1, LO write enable.
- in_hi, in, DATA_W, HI write data.
- in_lo, in, DATA_W, LO write data.
- rf_we, out, 1, GPR write enable to the register file and ID bypass.
- rf_waddr, out, RADDR_W, GPR write address.
- rf_wdata, out, DATA_W, GPR write data.
- hi_q, out, DATA_W, architectural HI, registered.
- lo_q, out, DATA_W, architectural LO, registered.
- hi_fwd, out, DATA_W, HI after this cycle's WB write, combinational bypass.
- lo_fwd, out, DATA_W, LO after this cycle's WB write, combinational bypass.
- debug_wb_pc, out, 32, PC of the instruction in WB.
- debug_wb_rf_wen, out, 4, {4{rf_we}}.
- debug_wb_rf_wnum, out, RADDR_W, GPR write address.
- debug_wb_rf_wdata, out, DATA_W, GPR write data.
- trace_valid, out, 1, trace FIFO non-empty.
- trace_ready, in, 1, trace consumer accepts the head entry.
- trace_pc, out, 32, head entry PC.
- trace_waddr, out, RADDR_W, head entry GPR write address.
- trace_wdata, out, DATA_W, head entry GPR write data.
- trace_ovf, out, 1, sticky flag: a retirement was dropped.
- retire_cnt, out, 32, count of retired instructions.
- bubble_cnt, out, 32, count of bubbles entering WB.

Function
REQ-007 SHALL hold a WB slot register {valid, pc, rf_we, waddr, wdata, hi_we, lo_we, hi, lo}.
REQ-008 SHALL update the slot each clock by the first matching rule:
- rst: clear.
- flush: clear.
- stall[4]=1 and stall[5]=0: clear (insert bubble).
- stall[4]=0: load inputs.
- otherwise: hold.
REQ-009 SHALL have an input-to-output latency of one cycle; the rf_*, debug_* and fwd outputs are combinational from the slot.
REQ-010 SHALL gate the effective enables as valid & in_*_we; an invalid slot SHALL present rf_we=0 regardless of field contents.
REQ-011 SHALL update hi_q and lo_q once per occupancy, on the clock edge where the slot is valid and the slot is not holding; a held slot SHALL NOT rewrite them.
REQ-012 SHALL drive hi_fwd = (valid & hi_we) ? slot.hi : hi_q, and lo_fwd likewise.
REQ-013 SHALL retire the slot on an edge where valid=1 and it is not holding. Retirement increments retire_cnt, which wraps modulo 2^32.
REQ-014 SHALL increment bubble_cnt on every edge on which rule (c) of REQ-008 applies; the counter wraps.
REQ-015 SHALL enqueue {pc, waddr, wdata} into the trace FIFO on each retirement with effective rf_we=1 and waddr!=0.
REQ-016 SHALL pop the trace FIFO when trace_valid & trace_ready; the FIFO is first-word-fall-through with zero-cycle head visibility.
REQ-017 SHALL, when the FIFO is full:
- with a same-cycle pop: perform push and pop together, count unchanged.
- with no pop: drop the push and set trace_ovf.
REQ-018 SHALL, when the FIFO is empty, ignore a pop; trace_valid=0.
REQ-019 SHALL use read and write pointers of log2(TRACE_DEPTH)+1 bits that wrap naturally; full = MSBs differ and low bits equal.

Reset
REQ-020 SHALL, on rst, clear the slot, hi_q, lo_q, both counters, FIFO pointers and trace_ovf. All outputs then read 0, trace_valid=0.
REQ-021 SHALL give rst priority over flush, stall and handshake in the same cycle; a reset mid-drain discards FIFO contents.

Verification
REQ-022 Load and retire: stall=0, valid, pc=0xBFC00000, we=1, waddr=8, wdata=0x1234 -> next cycle rf_we=1, debug_wb_rf_wen=4'hF; retire_cnt=1; trace head pc=0xBFC00000.
REQ-023 Bubble and hold:
- stall=6'b010000 -> slot cleared, bubble_cnt+1.
- stall=6'b110000 for 3 cycles -> outputs held, retire_cnt unchanged, hi_q written once.
REQ-024 HI/LO: hi_we=1, hi=0xDEAD -> that cycle hi_fwd=0xDEAD while hi_q=old value; next cycle hi_q=0xDEAD.
REQ-025 FIFO full (DEPTH=4), trace_ready=0:
- 5 writing retirements -> 4 entries held, trace_ovf=1.
- Then ready=1 -> 4 pops in order, trace_valid drops.
REQ-026 Simultaneous: full FIFO with push and pop in the same cycle -> no overflow, order preserved. waddr=0 retirement -> retire_cnt increments, no enqueue.
REQ-027 Flush with stall[4]=0 -> slot cleared, no retirement. rst asserted with a pending pop -> all state zero next cycle.
